// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Contents: opcode constants, aluop codes, the FSM state enum, the
// per-state control word and a helper that says whether an opcode is
// one this controller knows how to sequence.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP
  } statetype;

  // Moore outputs of one state. pcwrite/branch are internal and are
  // folded into pcen by the top level.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_word_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R)   || (op == OP_LW)   || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_ORI) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decoder.
// Ports:
//   state : current FSM state
//   cw    : Moore control word for that state (ungated; the top level
//           applies mem_ready and reset qualification)
module mc_outdec
  import mips_pkg::*;
(
  input  statetype   state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        // irwrite/pcwrite are qualified by mem_ready in the top level
        cw.mem_req = 1'b1;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = 2'b01;
        cw.aluop   = ALU_ADD;
        cw.pcsrc   = 2'b00;
      end
      DECODE: begin
        // branch target PC+4+(imm<<2) lands in ALUOut for BRANCH
        cw.alusrcb = 2'b11;
        cw.aluop   = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b10;
        cw.aluop   = ALU_ADD;
      end
      MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      MEMWR: begin
        cw.mem_req  = 1'b1;
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b00;
        cw.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      BRANCH: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b00;
        cw.aluop   = ALU_SUB;
        cw.pcsrc   = 2'b01;
        cw.branch  = 1'b1;
      end
      ORIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b10;
        cw.aluop   = ALU_OR;
      end
      IMMWB: begin
        cw.regwrite = 1'b1;
      end
      JUMP: begin
        cw.pcsrc   = 2'b10;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences the shared datapath through
// fetch/decode/execute/writeback, stalling on memory via mem_ready.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   op, zero, mem_ready : IR opcode, ALU zero flag, memory completion
//   mem_req, memwrite, iord, irwrite, pcen, regwrite : strobes/selects
//   regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop : datapath selects
//   illegal_op          : one-cycle flag on an unsupported opcode
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  statetype   state, next_state;
  ctrl_word_t cw;
  logic       rdy_ok;

  mc_outdec u_outdec (
    .state (state),
    .cw    (cw)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_ORI:       next_state = ORIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) next_state = MEMWB;
      MEMWR:   if (mem_ready) next_state = FETCH;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = IMMWB;
      ORIEX:   next_state = IMMWB;
      default: next_state = FETCH;
    endcase
  end

  // Write strobes that complete a memory access only fire once memory
  // accepts it; outside memory states they are unconditional (JUMP).
  assign rdy_ok = ~cw.mem_req | mem_ready;

  assign mem_req    = cw.mem_req  & ~reset;
  assign memwrite   = cw.memwrite & ~reset;
  assign irwrite    = cw.irwrite  & rdy_ok & ~reset;
  assign regwrite   = cw.regwrite & ~reset;
  assign pcen       = ((cw.pcwrite & rdy_ok) | (cw.branch & zero)) & ~reset;
  assign illegal_op = (state == DECODE) & ~op_legal(op) & ~reset;

  assign iord     = cw.iord;
  assign regdst   = cw.regdst;
  assign memtoreg = cw.memtoreg;
  assign alusrca  = cw.alusrca;
  assign alusrcb  = cw.alusrcb;
  assign pcsrc    = cw.pcsrc;
  assign aluop    = cw.aluop;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams with random memory stalls, checked against
// per-instruction rules (cycle counts, strobe counts, key selects).
module tb_mc_controller;

  localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011,
                         BEQ_OP = 6'b000100, ADDI_OP = 6'b001000,
                         ORI_OP = 6'b001101, J_OP = 6'b000010;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op;
  logic mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic illegal_op, rdy;
  } rec_t;

  rec_t rec [64];
  int   n, fs, ds;
  bit   done_ok;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] o);
    return o == R_OP || o == LW_OP || o == SW_OP || o == BEQ_OP ||
           o == ADDI_OP || o == ORI_OP || o == J_OP;
  endfunction

  function automatic int base_cycles(input logic [5:0] o);
    if (o == LW_OP) return 5;
    if (o == SW_OP || o == R_OP || o == ADDI_OP || o == ORI_OP) return 4;
    if (o == BEQ_OP || o == J_OP) return 3;
    return 2;
  endfunction

  function automatic logic [1:0] exec_aluop(input logic [5:0] o);
    if (o == R_OP)   return 2'b10;
    if (o == ORI_OP) return 2'b11;
    if (o == BEQ_OP) return 2'b01;
    return 2'b00;
  endfunction

  // Runs one instruction starting in FETCH (called just after a rising
  // edge) and records every cycle until the next FETCH is entered.
  // fforce/dforce: forced mem_ready=0 cycles in fetch / data access.
  task automatic run_instr(input logic [5:0] o, input logic z,
                           input int fforce, input int dforce, input bit rnd);
    bit prev_fetch, fetch_now;
    op = o; zero = z; n = 0; fs = 0; ds = 0; prev_fetch = 1'b1; done_ok = 1'b0;
    for (int i = 0; i < 60 && !done_ok; i++) begin
      #1;
      fetch_now = mem_req && !iord;
      if (n > 0 && fetch_now && !prev_fetch) done_ok = 1'b1;
      else begin
        if (mem_req) begin
          if (fetch_now ? (fforce > 0) : (dforce > 0)) begin
            mem_ready = 1'b0;
            if (fetch_now) fforce--; else dforce--;
          end else mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end else mem_ready = 1'($urandom_range(0, 1));
        #1;
        rec[n].mem_req = mem_req;   rec[n].memwrite = memwrite; rec[n].iord = iord;
        rec[n].irwrite = irwrite;   rec[n].pcen = pcen;         rec[n].regwrite = regwrite;
        rec[n].regdst = regdst;     rec[n].memtoreg = memtoreg; rec[n].alusrca = alusrca;
        rec[n].alusrcb = alusrcb;   rec[n].pcsrc = pcsrc;       rec[n].aluop = aluop;
        rec[n].illegal_op = illegal_op; rec[n].rdy = mem_ready;
        if (mem_req && !mem_ready) begin
          if (fetch_now) fs++; else ds++;
        end
        prev_fetch = fetch_now;
        n++;
        @(posedge clk);
      end
    end
    if (!done_ok) begin
      checks++; errors++;
      $display("FAIL timeout op=%b: no return to fetch after %0d cycles", o, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = LW_OP; zero = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      checks++;
      if ({mem_req, memwrite, irwrite, pcen, regwrite, illegal_op} !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes cycle %0d: got %b exp 000000", c,
                 {mem_req, memwrite, irwrite, pcen, regwrite, illegal_op});
      end
    end
    @(posedge clk); #1; reset = 1'b0;
    run_instr(LW_OP, 1'b0, 0, 0, 0);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lw_cycles: got %0d exp 5", n); end
    checks++;
    if (!(rec[0].mem_req && !rec[0].iord && rec[0].irwrite && rec[0].alusrcb == 2'b01)) begin
      errors++; $display("FAIL lw_fetch: got req=%b iord=%b ir=%b srcb=%b exp 1 0 1 01",
                         rec[0].mem_req, rec[0].iord, rec[0].irwrite, rec[0].alusrcb);
    end
    checks++;
    if (!(rec[2].alusrca && rec[2].alusrcb == 2'b10 && rec[3].mem_req && rec[3].iord)) begin
      errors++; $display("FAIL lw_memadr_memrd: got srca=%b srcb=%b req=%b iord=%b exp 1 10 1 1",
                         rec[2].alusrca, rec[2].alusrcb, rec[3].mem_req, rec[3].iord);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rec[c].regwrite, rec[c].memtoreg} !== ((c == 4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL lw_wb cycle %0d: got rw/m2r=%b exp %b", c,
                           {rec[c].regwrite, rec[c].memtoreg}, (c == 4) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_sw_stall();
    int mw;
    run_instr(SW_OP, 1'b0, 0, 2, 0);
    mw = 0;
    for (int c = 0; c < n; c++) mw += rec[c].memwrite;
    checks++;
    if (n !== 6 || mw != 3 || !(rec[3].memwrite && rec[4].memwrite && rec[5].memwrite)) begin
      errors++; $display("FAIL sw_stall: got cycles=%0d memwrite=%0d exp 6 3", n, mw);
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      run_instr(BEQ_OP, (k == 0), 0, 0, 0);
      checks++;
      if (n !== 3 || rec[2].pcsrc !== 2'b01 || rec[2].aluop !== 2'b01 ||
          rec[2].pcen !== (k == 0)) begin
        errors++; $display("FAIL beq zero=%0d: got n=%0d pcsrc=%b aluop=%b pcen=%b exp 3 01 01 %0d",
                           (k == 0), n, rec[2].pcsrc, rec[2].aluop, rec[2].pcen, (k == 0));
      end
    end
  endtask

  task automatic test_ori();
    run_instr(ORI_OP, 1'b1, 0, 0, 0);
    checks++;
    if (n !== 4 || rec[2].aluop !== 2'b11 || rec[2].alusrcb !== 2'b10 ||
        rec[3].regwrite !== 1'b1 || rec[3].regdst !== 1'b0) begin
      errors++; $display("FAIL ori: got n=%0d aluop=%b srcb=%b rw=%b rd=%b exp 4 11 10 1 0",
                         n, rec[2].aluop, rec[2].alusrcb, rec[3].regwrite, rec[3].regdst);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 1'b0, 0, 0, 0);
    checks++;
    if (n !== 2 || rec[0].illegal_op !== 1'b0 || rec[1].illegal_op !== 1'b1 ||
        rec[0].regwrite || rec[1].regwrite || rec[0].memwrite || rec[1].memwrite) begin
      errors++; $display("FAIL illegal: got n=%0d ill=%b%b exp 2 01", n,
                         rec[0].illegal_op, rec[1].illegal_op);
    end
  endtask

  task automatic test_fetch_stall();
    run_instr(R_OP, 1'b0, 4, 0, 0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rec[c].irwrite !== 1'b0 || rec[c].pcen !== 1'b0 || rec[c].mem_req !== 1'b1) begin
        errors++; $display("FAIL fetch_stall cycle %0d: got ir=%b pcen=%b req=%b exp 0 0 1",
                           c, rec[c].irwrite, rec[c].pcen, rec[c].mem_req);
      end
    end
    checks++;
    if (n !== 8 || rec[4].irwrite !== 1'b1 || rec[4].pcen !== 1'b1 || rec[5].alusrcb !== 2'b11) begin
      errors++; $display("FAIL fetch_release: got n=%0d ir=%b pcen=%b srcb=%b exp 8 1 1 11",
                         n, rec[4].irwrite, rec[4].pcen, rec[5].alusrcb);
    end
  endtask

  task automatic test_reset_midop();
    op = SW_OP; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b1) begin errors++; $display("FAIL midop_memwr: got %b exp 1", memwrite); end
    reset = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0 || mem_req !== 1'b0 || regwrite !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got mw=%b req=%b rw=%b exp 0 0 0", memwrite, mem_req, regwrite);
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || iord !== 1'b0 || memwrite !== 1'b0) begin
      errors++; $display("FAIL midop_fetch: got req=%b iord=%b mw=%b exp 1 0 0", mem_req, iord, memwrite);
    end
    @(posedge clk);
    #1;
    // a granted fetch was taken above only if mem_ready was high; bring
    // the FSM back to a known FETCH via reset
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{R_OP, LW_OP, SW_OP, BEQ_OP, ADDI_OP, ORI_OP, J_OP};
    logic [5:0] o;
    logic z;
    int c_ir, c_rw, c_mw, c_pc, c_il, wr;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 6'($urandom); while (legal(o));
      end else o = ops[$urandom_range(0, 6)];
      z = 1'($urandom_range(0, 1));
      run_instr(o, z, 0, 0, 1);
      c_ir = 0; c_rw = 0; c_mw = 0; c_pc = 0; c_il = 0;
      for (int c = 0; c < n; c++) begin
        c_ir += rec[c].irwrite; c_rw += rec[c].regwrite; c_mw += rec[c].memwrite;
        c_pc += rec[c].pcen;    c_il += rec[c].illegal_op;
      end
      wr = (o == LW_OP || o == R_OP || o == ADDI_OP || o == ORI_OP) ? 1 : 0;
      checks++;
      if (n != base_cycles(o) + fs + ds) begin
        errors++; $display("FAIL rnd_cycles op=%b: got %0d exp %0d", o, n, base_cycles(o) + fs + ds);
      end
      checks++;
      if (c_ir != 1 || fs >= n || rec[fs].irwrite !== 1'b1) begin
        errors++; $display("FAIL rnd_irwrite op=%b: got count=%0d exp 1 at cycle %0d", o, c_ir, fs);
      end
      checks++;
      if (c_rw != wr) begin errors++; $display("FAIL rnd_regwrite op=%b: got %0d exp %0d", o, c_rw, wr); end
      if (wr == 1 && n > 0) begin
        checks++;
        if (rec[n-1].regwrite !== 1'b1 || rec[n-1].memtoreg !== (o == LW_OP) ||
            rec[n-1].regdst !== (o == R_OP)) begin
          errors++; $display("FAIL rnd_wb op=%b: got rw=%b m2r=%b rd=%b", o,
                             rec[n-1].regwrite, rec[n-1].memtoreg, rec[n-1].regdst);
        end
      end
      checks++;
      if (c_mw != ((o == SW_OP) ? ds + 1 : 0)) begin
        errors++; $display("FAIL rnd_memwrite op=%b: got %0d exp %0d", o, c_mw, (o == SW_OP) ? ds + 1 : 0);
      end
      checks++;
      if (c_pc != 1 + ((o == J_OP || (o == BEQ_OP && z)) ? 1 : 0)) begin
        errors++; $display("FAIL rnd_pcen op=%b zero=%b: got %0d", o, z, c_pc);
      end
      checks++;
      if (c_il != (legal(o) ? 0 : 1)) begin
        errors++; $display("FAIL rnd_illegal op=%b: got %0d exp %0d", o, c_il, legal(o) ? 0 : 1);
      end
      if (legal(o) && fs + 2 < n) begin
        checks++;
        if ((o == J_OP) ? (rec[fs+2].pcsrc !== 2'b10) : (rec[fs+2].aluop !== exec_aluop(o))) begin
          errors++; $display("FAIL rnd_exec op=%b: got aluop=%b pcsrc=%b exp aluop=%b", o,
                             rec[fs+2].aluop, rec[fs+2].pcsrc, exec_aluop(o));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_stall();
    test_beq();
    test_ori();
    test_illegal();
    test_fetch_stall();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle MIPS main controller. It sequences the shared datapath (single ALU, single memory port, PC and IR registers) through fetch/decode/execute/writeback state by state. It drives the 2-bit aluop consumed by the existing ALU function decoder, plus all mux selects and write strobes. Memory accesses use a ready handshake so the FSM stalls on slow memory.

Parameters:
None; opcode and state encodings are fixed constants in the shared package.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
op  input  6  instr[31:26] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
memwrite  output  1  write strobe to memory
iord  output  1  0 = address from PC, 1 = address from ALUOut
irwrite  output  1  IR load enable
pcen  output  1  PC load enable = pcwrite | (branch & zero)
regwrite  output  1  register file write
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = Data register, 0 = ALUOut
alusrca  output  1  0 = PC, 1 = register A
alusrcb  output  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  output  2  00 = add, 01 = sub, 10 = use funct, 11 = or
illegal_op  output  1  1-cycle flag: unsupported opcode decoded

Behaviour:
- Moore FSM with 13 states; every output is decoded from the current state only, except pcen and the mem_ready gating described below.
- Unlisted outputs are 0 in each state.
- Reset: state <= FETCH on the next clk edge after reset is sampled high. While reset=1, all strobes are forced to 0: mem_req, memwrite, irwrite, pcen, regwrite, illegal_op.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, ORI=001101, J=000010.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite equal mem_ready.
  - Transition: to DECODE when mem_ready, else stay.
- DECODE:
  - Outputs: alusrcb=11, aluop=00 (branch target into ALUOut).
  - Transitions by op: LW/SW→MEMADR, R→EXECUTE, BEQ→BRANCH, ADDI→ADDIEX, ORI→ORIEX, J→JUMP.
  - Any other op: illegal_op=1 for this cycle, next state FETCH. No architectural write occurs.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Transition: LW→MEMRD, SW→MEMWR (op is stable in IR).
- MEMRD:
  - Outputs: mem_req=1, iord=1.
  - Transition: to MEMWB on mem_ready, else stay.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; then FETCH.
- MEMWR:
  - Outputs: mem_req=1, iord=1, memwrite=1, all held until mem_ready.
  - Transition: to FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10; then ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0; then FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - pcen = zero (combinational).
  - Transition: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; then IMMWB.
- ORIEX:
  - Outputs: alusrca=1, alusrcb=10, aluop=11; then IMMWB.
  - Zero-extension of the immediate is the datapath's job; this block does not control it.
- IMMWB: regwrite=1, regdst=0, memtoreg=0; then FETCH.
- JUMP: pcsrc=10, pcwrite=1; then FETCH.
- Cycle counts with mem_ready tied high: LW 5, SW 4, R 4, ADDI/ORI 4, BEQ 3, J 3, illegal 2. Each stall cycle adds exactly 1.
- Reset mid-operation (e.g. in MEMWR with mem_ready=0):
  - memwrite drops in the same cycle reset is high.
  - The FSM is in FETCH on the following cycle.
  - No pending write or regwrite is completed.
- zero is ignored in every state except BRANCH.

Decomposition:
- Package mips_pkg holds:
  - opcode constants;
  - state enum statetype (4-bit);
  - aluop constants ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR;
  - packed struct ctrl_word_t (all Moore outputs plus pcwrite and branch).
- One natural sub-module, mc_outdec: purely combinational, maps statetype to ctrl_word_t.
- mc_controller keeps the state register, next-state logic, mem_ready/reset gating and the pcen equation.

Test Plan:
- Reset held 3 cycles, then released with op=100011 and mem_ready=1 → all strobes 0 during reset. States follow FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 and memtoreg=1 only in cycle 5.
- SW with mem_ready low for 2 cycles in MEMWR → memwrite=1 for 3 consecutive cycles; FETCH on the 4th.
- BEQ twice, with zero=1 then zero=0 → BRANCH cycle shows pcsrc=01, aluop=01. pcen=1 for zero=1 and pcen=0 for zero=0.
- ORI op=001101 → ORIEX shows aluop=11 and alusrcb=10; IMMWB shows regwrite=1, regdst=0.
- op=111111 → illegal_op=1 in the DECODE cycle only; next cycle FETCH; regwrite and memwrite never asserted.
- FETCH with mem_ready=0 for 4 cycles → irwrite=0, pcen=0 and state held. On the mem_ready=1 cycle, irwrite=1 and pcen=1, then DECODE.
